// File: rtl/fsm_stepper_pkg.sv
// Shared types and constants for the 8-state sequencer stepper.
package fsm_stepper_pkg;

    localparam int unsigned NUM_ST           = 8;
    localparam int unsigned ST_W             = 3;
    localparam int unsigned TMR_W            = 8;
    localparam int unsigned DEF_STEP_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    function automatic logic [NUM_ST-1:0] st_onehot(input logic [ST_W-1:0] s);
        return NUM_ST'(1) << s;
    endfunction

    // Successor state on the ring; 3-bit add wraps 7 -> 0.
    function automatic logic [ST_W-1:0] st_next(input logic [ST_W-1:0] s);
        return s + ST_W'(1);
    endfunction

endpackage

// File: rtl/fsm_step_timer.sv
// Saturating WAIT-state timer; expired_c flags the cycle the count reaches LIMIT.
module fsm_step_timer
    import fsm_stepper_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_STEP_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam logic [TMR_W:0] LIM_X = (TMR_W+1)'(LIMIT);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Lookahead: the increment taken this cycle reaches the limit.
    assign expired_c = enable_i && (({1'b0, cnt_q} + (TMR_W+1)'(1)) >= LIM_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_se8s_stepper.sv
// Walks an 8-state ring sequencer forward to a requested state, one strobe per step,
// with a timeout and unexpected-jump detection.
module fsm_se8s_stepper
    import fsm_stepper_pkg::*;
#(
    parameter int unsigned STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ST_W-1:0]   req_target,
    output logic              req_ready,
    input  logic [ST_W-1:0]   st_in,
    output logic [NUM_ST-1:0] t_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [ST_W-1:0]     tgt_q, tgt_d;
    logic [ST_W-1:0]     prev_q, prev_d;
    logic [ST_W-1:0]     exp_q, exp_d;
    logic [NUM_ST-1:0]   t_out_q, t_out_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tmr_clr, tmr_en, tmr_exp;

    fsm_step_timer #(.LIMIT(STEP_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_c (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        prev_d  = prev_q;
        exp_d   = exp_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tgt_d   = req_target;
                    state_d = (st_in == req_target) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                tmr_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                if (st_in == exp_q) begin
                    state_d = (exp_q == tgt_q) ? S_DONE : S_STEP;
                end else if (st_in != prev_q) begin
                    state_d = S_ERR;
                end else if (tmr_exp) begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase

        // Position is captured on entry to STEP so the strobe comes straight from a flop.
        if (state_d == S_STEP) begin
            prev_d = st_in;
            exp_d  = st_next(st_in);
        end

        t_out_d = (state_d == S_STEP) ? st_onehot(st_in) : '0;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            prev_q  <= '0;
            exp_q   <= '0;
            t_out_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            prev_q  <= prev_d;
            exp_q   <= exp_d;
            t_out_q <= t_out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign t_out     = t_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
